// File: rtl/przerwania_pkg.sv
// Shared types and helpers for the interrupt controller (kontroler_przerwan).
// Fixed priority by default; `define PRIO_ROTATE_EN selects rotating priority.
package przerwania_pkg;

   typedef enum logic [1:0] {IDLE, REQ, SERWIS} stan_t;

   localparam int MASK_GLOBAL_BIT = 7;

   // First set bit of req[n-1:0], searching upward from start and wrapping at n.
   // Sources never exceed 7, so an 8-bit vector and a 3-bit result cover every build.
   function automatic logic [2:0] first_set(input logic [7:0] req, input int n, input int start);
      logic [2:0] res;
      int         idx;
      res = '0;
      for (int k = 7; k >= 0; k--) begin
         if (k < n) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (req[idx[2:0]]) res = idx[2:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/przerwania_arbiter.sv
// Combinational winner pick from the eligible vector, starting at a given index.
// start=0 gives fixed priority (source 0 highest); any other start rotates.
module przerwania_arbiter
   import przerwania_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int VEC_W = 2
) (
   input  logic [N_SRC-1:0] eligible,
   input  logic [VEC_W-1:0] start,
   output logic [VEC_W-1:0] winner,
   output logic             any_valid
);

   logic [2:0] pick;

   always_comb begin
      pick      = first_set(8'(eligible), N_SRC, int'(start));
      winner    = VEC_W'(pick);
      any_valid = |eligible;
   end

endmodule

// File: rtl/kontroler_przerwan.sv
// Interrupt controller: edge-latched pending requests, mask register, irq/ack/reti handshake.
// Optional macro PRIO_ROTATE_EN switches the arbiter from fixed to rotating priority.
module kontroler_przerwan
   import przerwania_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int VEC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_int,
   input  logic [7:0]       wartosc,
   input  logic             zapisz_mask,
   output logic             irq,
   input  logic             irq_ack,
   output logic [VEC_W-1:0] vector,
   input  logic             reti,
   output logic [N_SRC-1:0] src_clr,
   output logic [N_SRC-1:0] pending,
   output stan_t            stan
);

   // Handshake: irq stays high for every cycle spent in REQ; irq_ack is honoured only
   // in REQ with a valid winner, reti only in SERWIS; anything else is ignored.

   logic [7:0]       mask;
   logic [N_SRC-1:0] src_prev;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] pending_n;
   logic [N_SRC-1:0] clr_n;
   logic [VEC_W-1:0] winner;
   logic [VEC_W-1:0] start;
   logic             any_valid;
   logic             take_ack;
   stan_t            stan_n;
   logic             mask_unused;

   // Mask bits between the source enables and the global bit are storage only.
   assign mask_unused = ^mask;

   assign rise     = src_int & ~src_prev;
   assign eligible = pending & mask[N_SRC-1:0] & {N_SRC{mask[MASK_GLOBAL_BIT]}};

`ifdef PRIO_ROTATE_EN
   logic [VEC_W-1:0] last_served;
   logic             served_any;

   // served_any separates "nothing served yet" from "source 0 served last".
   always_ff @(posedge clk) begin
      if (rst) begin
         last_served <= '0;
         served_any  <= 1'b0;
      end else if (take_ack) begin
         last_served <= winner;
         served_any  <= 1'b1;
      end
   end

   always_comb begin
      start = '0;
      if (served_any && (last_served != VEC_W'(N_SRC - 1))) start = last_served + VEC_W'(1);
   end
`else
   assign start = '0;
`endif

   przerwania_arbiter #(
      .N_SRC(N_SRC),
      .VEC_W(VEC_W)
   ) u_arbiter (
      .eligible (eligible),
      .start    (start),
      .winner   (winner),
      .any_valid(any_valid)
   );

   always_comb begin
      stan_n   = stan;
      take_ack = 1'b0;
      irq      = 1'b0;
      case (stan)
         IDLE: begin
            if (any_valid) stan_n = REQ;
         end
         REQ: begin
            irq = 1'b1;
            if (irq_ack && any_valid) begin
               stan_n   = SERWIS;
               take_ack = 1'b1;
            end else if (!any_valid) begin
               stan_n = IDLE;
            end
         end
         SERWIS: begin
            if (reti) stan_n = IDLE;
         end
         default: stan_n = IDLE;
      endcase
   end

   // A new edge on the source being cleared wins over the clear.
   always_comb begin
      clr_n = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (take_ack && (winner == VEC_W'(i))) clr_n[i] = 1'b1;
      end
      pending_n = (pending & ~clr_n) | rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask     <= 8'h00;
         src_prev <= '0;
         pending  <= '0;
         vector   <= '0;
         src_clr  <= '0;
         stan     <= IDLE;
      end else begin
         if (zapisz_mask) mask <= wartosc;
         src_prev <= src_int;
         pending  <= pending_n;
         src_clr  <= clr_n;
         stan     <= stan_n;
         if (take_ack) vector <= winner;
      end
   end

endmodule

// File: tb/tb_kontroler_przerwan.sv
// Self-checking bench for kontroler_przerwan in its default (fixed priority) build.
module tb_kontroler_przerwan;
   import przerwania_pkg::*;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] src_int = '0;
   logic [7:0]   wartosc = '0;
   logic         zapisz_mask = 1'b0;
   logic         irq_ack = 1'b0;
   logic         reti = 1'b0;
   logic         irq;
   logic [W-1:0] vector;
   logic [N-1:0] src_clr;
   logic [N-1:0] pending;
   stan_t        stan;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v;
   logic [N-1:0] exp_clr;

   kontroler_przerwan #(.N_SRC(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_int    (src_int),
      .wartosc    (wartosc),
      .zapisz_mask(zapisz_mask),
      .irq        (irq),
      .irq_ack    (irq_ack),
      .vector     (vector),
      .reti       (reti),
      .src_clr    (src_clr),
      .pending    (pending),
      .stan       (stan)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [7:0] v);
      wartosc     = v;
      zapisz_mask = 1'b1;
      tick();
      zapisz_mask = 1'b0;
   endtask

   task automatic pulse_src(input logic [N-1:0] bits);
      src_int = bits;
      tick();
      src_int = '0;
   endtask

   task automatic do_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic do_reti();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic pop_exp();
      if (exp_q.size() > 0) exp_v = exp_q.pop_front();
      else exp_v = 'x;
      exp_clr = 4'b0001 << exp_v;
   endtask

   task automatic wait_irq(input string name);
      int n = 0;
      while (irq !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL %s_irq_wait: irq=%b after %0d cycles, required 1", name, irq, n);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b required 0000", pending); end
      checks++; if (vector !== 2'd0) begin errors++; $display("FAIL reset_vector: got %0d required 0", vector); end
      checks++; if (src_clr !== 4'b0000) begin errors++; $display("FAIL reset_src_clr: got %b required 0000", src_clr); end
      checks++; if (stan !== IDLE) begin errors++; $display("FAIL reset_state: got %s required IDLE", stan.name()); end
      write_mask(8'h81);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after_mask: got %b required 0", irq); end
   endtask

   task automatic test_single();
      pulse_src(4'b0001);
      exp_q.push_back(2'd0);
      checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL single_pending_latency: got %b required 0001", pending); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_early: got %b required 0", irq); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq_latency: got %b required 1", irq); end
      do_ack();
      pop_exp();
      checks++; if (vector !== exp_v) begin errors++; $display("FAIL single_vector: got %0d required %0d", vector, exp_v); end
      checks++; if (src_clr !== exp_clr) begin errors++; $display("FAIL single_src_clr: got %b required %b", src_clr, exp_clr); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pending_clear: got %b required 0000", pending); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_in_serwis: got %b required 0", irq); end
      tick();
      checks++; if (src_clr !== 4'b0000) begin errors++; $display("FAIL single_src_clr_width: got %b required 0000", src_clr); end
      do_reti();
      checks++; if (stan !== IDLE) begin errors++; $display("FAIL single_reti_state: got %s required IDLE", stan.name()); end
      tick(); tick(); tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_no_spurious_irq: got %b required 0", irq); end
   endtask

   task automatic test_priority();
      write_mask(8'h8F);
      pulse_src(4'b1010);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd3);
      for (int k = 0; k < 2; k++) begin
         wait_irq("priority");
         do_ack();
         pop_exp();
         checks++; if (vector !== exp_v) begin errors++; $display("FAIL priority_vector_%0d: got %0d required %0d", k, vector, exp_v); end
         checks++; if (src_clr !== exp_clr) begin errors++; $display("FAIL priority_src_clr_%0d: got %b required %b", k, src_clr, exp_clr); end
         do_reti();
      end
   endtask

   task automatic test_global_mask();
      write_mask(8'h01);
      pulse_src(4'b0001);
      checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL gmask_pending: got %b required 0001", pending); end
      tick(); tick(); tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL gmask_irq_blocked: got %b required 0", irq); end
      write_mask(8'h81);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL gmask_irq_write_cycle: got %b required 0", irq); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL gmask_irq_enabled: got %b required 1", irq); end
      write_mask(8'h80);
      tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL gmask_irq_withdrawn: got %b required 0", irq); end
      checks++; if (stan !== IDLE) begin errors++; $display("FAIL gmask_state_idle: got %s required IDLE", stan.name()); end
      checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL gmask_pending_kept: got %b required 0001", pending); end
      write_mask(8'h81);
      exp_q.push_back(2'd0);
      wait_irq("gmask");
      do_ack();
      pop_exp();
      checks++; if (vector !== exp_v) begin errors++; $display("FAIL gmask_vector: got %0d required %0d", vector, exp_v); end
      do_reti();
   endtask

   task automatic test_set_wins();
      write_mask(8'h8F);
      pulse_src(4'b0100);
      exp_q.push_back(2'd2);
      wait_irq("setwins");
      src_int = 4'b0100;
      do_ack();
      src_int = '0;
      exp_q.push_back(2'd2);
      pop_exp();
      checks++; if (vector !== exp_v) begin errors++; $display("FAIL setwins_vector: got %0d required %0d", vector, exp_v); end
      checks++; if (src_clr !== exp_clr) begin errors++; $display("FAIL setwins_src_clr: got %b required %b", src_clr, exp_clr); end
      checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL setwins_pending: got %b required 0100", pending); end
      do_reti();
      wait_irq("setwins_again");
      do_ack();
      pop_exp();
      checks++; if (vector !== exp_v) begin errors++; $display("FAIL setwins_vector2: got %0d required %0d", vector, exp_v); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL setwins_pending2: got %b required 0000", pending); end
      do_reti();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] pat;
      int           guard;
      write_mask(8'h8F);
      for (int it = 0; it < 6; it++) begin
         pat = N'($urandom_range(1, 15));
         pulse_src(pat);
         for (int b = 0; b < N; b++) if (pat[b]) exp_q.push_back(W'(b));
         guard = 0;
         while (exp_q.size() > 0 && guard < 8) begin
            guard++;
            wait_irq("b2b");
            // reti alongside ack in REQ must be ignored
            reti = it[0];
            do_ack();
            reti = 1'b0;
            pop_exp();
            checks++; if (vector !== exp_v) begin errors++; $display("FAIL b2b_vector: got %0d required %0d pat=%b", vector, exp_v, pat); end
            checks++; if (src_clr !== exp_clr) begin errors++; $display("FAIL b2b_src_clr: got %b required %b", src_clr, exp_clr); end
            checks++; if (stan !== SERWIS) begin errors++; $display("FAIL b2b_state_serwis: got %s required SERWIS", stan.name()); end
            irq_ack = it[0];
            do_reti();
            irq_ack = 1'b0;
            checks++; if (stan !== IDLE) begin errors++; $display("FAIL b2b_state_idle: got %s required IDLE", stan.name()); end
         end
      end
   endtask

   task automatic test_rst_mid();
      write_mask(8'h8F);
      pulse_src(4'b0111);
      exp_q.push_back(2'd0);
      wait_irq("rstmid");
      do_ack();
      pop_exp();
      checks++; if (vector !== exp_v) begin errors++; $display("FAIL rstmid_vector: got %0d required %0d", vector, exp_v); end
      checks++; if (pending !== 4'b0110) begin errors++; $display("FAIL rstmid_pending_before: got %b required 0110", pending); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (stan !== IDLE) begin errors++; $display("FAIL rstmid_state: got %s required IDLE", stan.name()); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rstmid_pending: got %b required 0000", pending); end
      checks++; if ({irq, vector, src_clr} !== '0) begin errors++; $display("FAIL rstmid_outputs: got irq=%b vector=%0d src_clr=%b required all 0", irq, vector, src_clr); end
      irq_ack = 1'b1;
      reti    = 1'b1;
      tick();
      irq_ack = 1'b0;
      reti    = 1'b0;
      checks++; if (stan !== IDLE) begin errors++; $display("FAIL spurious_state: got %s required IDLE", stan.name()); end
      checks++; if ({irq, vector, src_clr} !== '0) begin errors++; $display("FAIL spurious_outputs: got irq=%b vector=%0d src_clr=%b required all 0", irq, vector, src_clr); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_priority();
      test_global_mask();
      test_set_wins();
      test_back_to_back();
      test_rst_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
